// File: rtl/mod_pkg.sv
// Shared constants for the Kyber/Dilithium modular arithmetic datapath.
package mod_pkg;

  localparam int DATA_W      = 23;
  localparam int KYBER_W     = 12;
  localparam int DILITHIUM_W = 23;

  localparam logic [DATA_W-1:0] KYBER_Q       = 23'd3329;
  localparam logic [DATA_W-1:0] DILITHIUM_Q   = 23'd8380417;
  localparam logic [DATA_W-1:0] KYBER_EXP     = 23'd3327;
  localparam logic [DATA_W-1:0] DILITHIUM_EXP = 23'd8380415;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} inv_state_t;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: c = a*b mod q, q chosen by select_i.
module mod_mul
  import mod_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              select_i,
  output logic [DATA_W-1:0] c_o
);

  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_q;

  always_comb begin
    w_prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    w_q    = select_i ? {{DATA_W{1'b0}}, KYBER_Q} : {{DATA_W{1'b0}}, DILITHIUM_Q};
    c_o    = DATA_W'(w_prod % w_q);
  end

endmodule

// File: rtl/mod_inv.sv
// Constant-time modular inverse via Fermat (a^(q-2) mod q), left-to-right
// square-and-multiply over one shared mod_mul.
module mod_inv
  import mod_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic              select_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] c_o,
  output logic              div0_o
);

  inv_state_t        r_state;
  inv_state_t        w_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_res;
  logic              r_sel;
  logic              r_div0;
  logic [4:0]        r_bitIdx;

  logic [DATA_W-1:0] w_opB;
  logic [DATA_W-1:0] w_prod;
  logic [31:0]       w_exp;
  logic              w_expBit;
  logic [DATA_W-1:0] w_resOut;

  assign w_opB    = (r_state == SQR) ? r_res : r_a;
  assign w_exp    = {9'd0, (r_sel ? KYBER_EXP : DILITHIUM_EXP)};
  assign w_expBit = w_exp[r_bitIdx];
  assign w_resOut = r_sel ? {{(DATA_W-KYBER_W){1'b0}}, r_res[KYBER_W-1:0]} : r_res;

  mod_mul u_mul (
    .a_i      (r_res),
    .b_i      (w_opB),
    .select_i (r_sel),
    .c_o      (w_prod)
  );

  always_comb begin
    w_next  = r_state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    c_o     = '0;
    div0_o  = 1'b0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) w_next = SQR;
      end
      SQR: w_next = MUL;
      MUL: w_next = (r_bitIdx == 5'd0) ? DONE : SQR;
      DONE: begin
        valid_o = 1'b1;
        c_o     = w_resOut;
        div0_o  = r_div0;
        if (ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The exponent MSB is always 1 and is consumed by seeding res with a.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_res    <= '0;
      r_sel    <= 1'b0;
      r_div0   <= 1'b0;
      r_bitIdx <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_a      <= a_i;
            r_res    <= a_i;
            r_sel    <= select_i;
            r_div0   <= (a_i == '0);
            r_bitIdx <= select_i ? 5'(KYBER_W - 2) : 5'(DILITHIUM_W - 2);
          end
        end
        SQR: r_res <= w_prod;
        MUL: begin
          if (w_expBit) r_res <= w_prod;
          if (r_bitIdx != 5'd0) r_bitIdx <= r_bitIdx - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && ready_o) |-> (a_i < (select_i ? KYBER_Q : DILITHIUM_Q)));

endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: expected inverses come from extended Euclid.
module tb_mod_inv;
  import mod_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              validIn;
  logic              readyOut;
  logic [DATA_W-1:0] aIn;
  logic              selIn;
  logic              validOut;
  logic              readyIn;
  logic [DATA_W-1:0] cOut;
  logic              div0Out;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic              sel;
    logic [DATA_W-1:0] c;
    logic              div0;
    int                acceptCycle;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int       cycle      = 0;
  int       errorCount = 0;
  int       checkCount = 0;
  bit       seenValid  = 1'b0;

  mod_inv dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (validIn),
    .ready_o  (readyOut),
    .a_i      (aIn),
    .select_i (selIn),
    .valid_o  (validOut),
    .ready_i  (readyIn),
    .c_o      (cOut),
    .div0_o   (div0Out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  function automatic longint modInverse(input longint a, input longint q);
    longint t, newT, r, newR, quo, tmp;
    if (a == 0) return 0;
    t = 0; newT = 1; r = q; newR = a;
    while (newR != 0) begin
      quo  = r / newR;
      tmp  = t - quo * newT; t = newT; newT = tmp;
      tmp  = r - quo * newR; r = newR; newR = tmp;
    end
    if (t < 0) t += q;
    return t;
  endfunction

  function automatic longint modulus(input logic sel);
    return sel ? longint'(KYBER_Q) : longint'(DILITHIUM_Q);
  endfunction

  // Results are compared when handed off; latency is taken at first sight of valid_o.
  always @(negedge clk) begin
    sbEntry_t e;
    if (!rst && validOut) begin
      if (sbQueue.size() == 0) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        if (!seenValid) begin
          seenValid = 1'b1;
          checkOutput("latency", cycle - sbQueue[0].acceptCycle + 1, sbQueue[0].sel ? 23 : 45);
        end
        if (readyIn) begin
          e = sbQueue.pop_front();
          seenValid = 1'b0;
          checkOutput("result", cOut, e.c);
          checkOutput("div0", div0Out, e.div0);
          if (e.a != 0)
            checkOutput("inverseProduct", (longint'(e.a) * longint'(cOut)) % modulus(e.sel), 1);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic sel, input bit hold);
    sbEntry_t e;
    int       n;
    bit       rdy;
    @(posedge clk); #1;
    aIn = a; selIn = sel; validIn = 1'b1;
    n = 0; rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = readyOut;
      n++;
    end
    if (!rdy) begin
      checkOutput("acceptTimeout", 0, 1);
      validIn = 1'b0;
      return;
    end
    checkOutput("idleQueueEmpty", sbQueue.size(), 0);
    e.a = a; e.sel = sel;
    e.c = DATA_W'(modInverse(longint'(a), modulus(sel)));
    e.div0 = (a == '0);
    e.acceptCycle = cycle + 1;
    sbQueue.push_back(e);
    @(posedge clk); #1;
    if (!hold) validIn = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sbQueue.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checkOutput("drainTimeout", sbQueue.size(), 0);
      sbQueue.delete();
      seenValid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; validIn = 1'b0; aIn = '0; selIn = 1'b0; readyIn = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetReady", readyOut, 1);
    checkOutput("resetValid", validOut, 0);
    checkOutput("resetC", cOut, 0);
    checkOutput("resetDiv0", div0Out, 0);

    $display("[TB] directed values, both moduli, including zero operand");
    applyStimulus(23'd2, 1'b1, 1'b0);       waitDrain(100);
    applyStimulus(23'd3, 1'b1, 1'b0);       waitDrain(100);
    applyStimulus(23'd3328, 1'b1, 1'b0);    waitDrain(100);
    applyStimulus(23'd1, 1'b1, 1'b0);       waitDrain(100);
    applyStimulus(23'd2, 1'b0, 1'b0);       waitDrain(100);
    applyStimulus(23'd3, 1'b0, 1'b0);       waitDrain(100);
    applyStimulus(23'd8380416, 1'b0, 1'b0); waitDrain(100);
    applyStimulus(23'd0, 1'b1, 1'b0);       waitDrain(100);
    applyStimulus(23'd0, 1'b0, 1'b0);       waitDrain(100);

    $display("[TB] backpressure and back-to-back");
    readyIn = 1'b0;
    applyStimulus(23'd2, 1'b1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!validOut && n < 100);
    for (int i = 0; i < 10; i++) begin
      checkOutput("holdValid", validOut, 1);
      checkOutput("holdC", cOut, 1665);
      checkOutput("holdDiv0", div0Out, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 readyIn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bubbleReady", readyOut, 1);
    checkOutput("bubbleValid", validOut, 0);
    applyStimulus(23'd2, 1'b1, 1'b0);
    applyStimulus(23'd3, 1'b0, 1'b0);
    waitDrain(100);

    $display("[TB] inputs toggled mid-operation, valid held while busy");
    applyStimulus(23'd2, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      aIn = DATA_W'($urandom);
      selIn = ~selIn;
    end
    waitDrain(100);
    applyStimulus(23'd5, 1'b1, 1'b1);
    applyStimulus(23'd5, 1'b1, 1'b0);
    waitDrain(100);

    $display("[TB] reset mid-operation");
    applyStimulus(23'd2, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    sbQueue.delete();
    seenValid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abortReady", readyOut, 1);
    checkOutput("abortValid", validOut, 0);
    checkOutput("abortC", cOut, 0);
    applyStimulus(23'd2, 1'b0, 1'b0);
    waitDrain(100);

    $display("[TB] random operands");
    for (int i = 0; i < 8; i++) begin
      logic s;
      s = i[0];
      applyStimulus(DATA_W'($urandom_range(0, int'(modulus(s)) - 1)), s, 1'b0);
      waitDrain(100);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
